// File: rtl/dft_seq_pkg.sv
// Shared definitions for the DFT run sequencer.
//   seq_state_t : sequencer FSM states
//   RST_CYCLES  : number of cycles dut_rst is held high at the start of a run
//   ERR_OVF     : err bit index, scan-word buffer overflow
//   ERR_TMO     : err bit index, handshake watchdog timeout
package dft_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RST,
        ST_OP_REQ,
        ST_OP_CMT,
        ST_DFT_REQ,
        ST_DFT_CMT,
        ST_DONE
    } seq_state_t;

    localparam int RST_CYCLES = 2;
    localparam int ERR_OVF    = 0;
    localparam int ERR_TMO    = 1;

endpackage

// File: rtl/dft_seq_fifo.sv
// Synchronous scan-word FIFO with a registered head word.
//   clk, reset   : clock, asynchronous active-high reset
//   flush        : empties the FIFO (wins over push/pop)
//   push, push_data : write request and word; ignored when full unless a pop
//                     happens in the same cycle
//   pop          : read request; ignored when empty
//   head_data    : registered oldest word, valid while empty is low
//   full, empty  : occupancy flags
module dft_seq_fifo #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] head_data,
    output logic              full,
    output logic              empty
);

    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr_reg, rd_ptr_reg, rd_ptr_next;
    logic [AW:0]       count_reg, count_next, count_after_pop;
    logic [DATA_W-1:0] head_reg;
    logic              push_ok, pop_ok;

    assign full  = (count_reg == (AW+1)'(DEPTH));
    assign empty = (count_reg == '0);

    // A pop frees a slot in the same cycle, so a full FIFO still accepts a push
    // that coincides with a pop.
    assign pop_ok          = pop && !empty && !flush;
    assign push_ok         = push && (!full || pop_ok) && !flush;
    assign rd_ptr_next     = rd_ptr_reg + AW'(pop_ok);
    assign count_after_pop = count_reg - (AW+1)'(pop_ok);
    assign count_next      = count_after_pop + (AW+1)'(push_ok);
    assign head_data       = head_reg;

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            head_reg   <= '0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
            // The head register is refreshed whenever occupancy changes. When
            // the FIFO would otherwise be empty, the word being pushed bypasses
            // the array so it is visible one cycle after the push.
            if ((push_ok || pop_ok) && count_next != '0) begin
                head_reg <= (count_after_pop == '0) ? push_data : mem[rd_ptr_next];
            end
        end
    end

endmodule

// File: rtl/dft_run_sequencer.sv
// Autonomous DFT test-run controller.
// On an accepted cmd_start it resets the DUT for RST_CYCLES cycles, then runs
// max(cmd_dumps,1) rounds of { cmd_ops DUT op/commit handshakes, one DFT
// dump handshake (skipped when cmd_dumps is 0) }, buffering every strobed scan
// word in a FIFO the host drains through rd_data/rd_valid/rd_ready.
// Ports:
//   clk, reset                        : clock, asynchronous active-high reset
//   cmd_start/cmd_stim/cmd_ops/cmd_dumps : run command, latched on start
//   busy, done, err[1:0]              : run status; err is sticky until next start
//   dut_rst, dut_input_vec            : DUT reset and latched stimulus
//   dut_val_op/dut_op_commit, dut_op_ack/dut_commit_ack : DUT handshake
//   dut_sen                           : scan enable during DFT handshakes
//   dft_val_op/dft_op_commit, dft_op_ack/dft_commit_ack : DFT handshake
//   dft_output_strobe/dft_output_data : scan words to buffer
//   rd_data, rd_valid, rd_ready       : host drain port
// Build option: define DFT_SEQ_TIMEOUT_EN to add a handshake watchdog of
// TIMEOUT_CYC cycles that sets err[1] and aborts the run.
module dft_run_sequencer
    import dft_seq_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int CNT_W       = 16,
    parameter int BUF_DEPTH   = 8,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_start,
    input  logic [DATA_W-1:0] cmd_stim,
    input  logic [CNT_W-1:0]  cmd_ops,
    input  logic [CNT_W-1:0]  cmd_dumps,
    output logic              busy,
    output logic              done,
    output logic [1:0]        err,
    output logic              dut_rst,
    output logic [DATA_W-1:0] dut_input_vec,
    output logic              dut_val_op,
    output logic              dut_op_commit,
    input  logic              dut_op_ack,
    input  logic              dut_commit_ack,
    output logic              dut_sen,
    output logic              dft_val_op,
    output logic              dft_op_commit,
    input  logic              dft_op_ack,
    input  logic              dft_commit_ack,
    input  logic              dft_output_strobe,
    input  logic [DATA_W-1:0] dft_output_data,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    input  logic              rd_ready
);

    localparam int RC_W = $clog2(RST_CYCLES + 1);

    seq_state_t        state_reg, state_next;
    logic [RC_W-1:0]   rst_cnt_reg;
    logic [CNT_W-1:0]  ops_cnt_reg, ops_lat_reg, round_cnt_reg;
    logic              dumps_nz_reg;
    logic [DATA_W-1:0] stim_reg;
    logic [1:0]        err_reg;
    logic              start_acc, tmo_hit, ovf_hit;
    logic              fifo_full, fifo_empty;

    assign start_acc     = (state_reg == ST_IDLE) && cmd_start;
    assign err           = err_reg;
    assign dut_input_vec = stim_reg;
    assign rd_valid      = !fifo_empty;

    // Dropped word: strobe into a full FIFO that is not being drained this cycle.
    assign ovf_hit = dft_output_strobe && fifo_full && !(rd_ready && !fifo_empty);

    // Next state and Moore outputs.
    always_comb begin
        state_next    = state_reg;
        busy          = 1'b1;
        done          = 1'b0;
        dut_rst       = 1'b0;
        dut_val_op    = 1'b0;
        dut_op_commit = 1'b0;
        dut_sen       = 1'b0;
        dft_val_op    = 1'b0;
        dft_op_commit = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                busy = 1'b0;
                if (cmd_start) state_next = ST_RST;
            end
            ST_RST: begin
                dut_rst = 1'b1;
                if (rst_cnt_reg == RC_W'(RST_CYCLES - 1)) begin
                    if (ops_lat_reg != '0)  state_next = ST_OP_REQ;
                    else if (dumps_nz_reg)  state_next = ST_DFT_REQ;
                    else                    state_next = ST_DONE;
                end
            end
            ST_OP_REQ: begin
                dut_val_op = 1'b1;
                if (dut_op_ack) state_next = ST_OP_CMT;
            end
            ST_OP_CMT: begin
                dut_op_commit = 1'b1;
                if (dut_commit_ack) begin
                    if (ops_cnt_reg > CNT_W'(1)) state_next = ST_OP_REQ;
                    else if (dumps_nz_reg)       state_next = ST_DFT_REQ;
                    else                         state_next = ST_DONE;
                end
            end
            ST_DFT_REQ: begin
                dft_val_op = 1'b1;
                dut_sen    = 1'b1;
                if (dft_op_ack) state_next = ST_DFT_CMT;
            end
            ST_DFT_CMT: begin
                dft_op_commit = 1'b1;
                dut_sen       = 1'b1;
                if (dft_commit_ack) begin
                    if (round_cnt_reg > CNT_W'(1))
                        state_next = (ops_lat_reg != '0) ? ST_OP_REQ : ST_DFT_REQ;
                    else
                        state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                busy       = 1'b0;
                done       = 1'b1;
                state_next = ST_IDLE;
            end
            default: begin
                busy       = 1'b0;
                state_next = ST_IDLE;
            end
        endcase
        if (tmo_hit) state_next = ST_DONE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= ST_IDLE;
            rst_cnt_reg   <= '0;
            ops_cnt_reg   <= '0;
            ops_lat_reg   <= '0;
            round_cnt_reg <= '0;
            dumps_nz_reg  <= 1'b0;
            stim_reg      <= '0;
            err_reg       <= '0;
        end else begin
            state_reg   <= state_next;
            rst_cnt_reg <= (state_reg == ST_RST && state_next == ST_RST) ?
                           rst_cnt_reg + RC_W'(1) : '0;
            if (start_acc) begin
                stim_reg      <= cmd_stim;
                ops_lat_reg   <= cmd_ops;
                ops_cnt_reg   <= cmd_ops;
                // A zero dump count still runs one round of ops.
                round_cnt_reg <= (cmd_dumps == '0) ? CNT_W'(1) : cmd_dumps;
                dumps_nz_reg  <= (cmd_dumps != '0);
                err_reg       <= '0;
            end else begin
                if (state_reg == ST_OP_CMT && dut_commit_ack && ops_cnt_reg != '0)
                    ops_cnt_reg <= ops_cnt_reg - CNT_W'(1);
                if (state_reg == ST_DFT_CMT && dft_commit_ack) begin
                    if (round_cnt_reg != '0)
                        round_cnt_reg <= round_cnt_reg - CNT_W'(1);
                    if (round_cnt_reg > CNT_W'(1))
                        ops_cnt_reg <= ops_lat_reg;
                end
                if (ovf_hit) err_reg[ERR_OVF] <= 1'b1;
                if (tmo_hit) err_reg[ERR_TMO] <= 1'b1;
            end
        end
    end

`ifdef DFT_SEQ_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYC + 1);

    logic [WD_W-1:0] wd_cnt_reg;
    logic            in_hs, hs_ack;

    always_comb begin
        in_hs  = 1'b0;
        hs_ack = 1'b0;
        case (state_reg)
            ST_OP_REQ:  begin in_hs = 1'b1; hs_ack = dut_op_ack;     end
            ST_OP_CMT:  begin in_hs = 1'b1; hs_ack = dut_commit_ack; end
            ST_DFT_REQ: begin in_hs = 1'b1; hs_ack = dft_op_ack;     end
            ST_DFT_CMT: begin in_hs = 1'b1; hs_ack = dft_commit_ack; end
            default:    begin in_hs = 1'b0; hs_ack = 1'b0;           end
        endcase
    end

    // Fires in the TIMEOUT_CYC-th consecutive cycle of one handshake state
    // without its acknowledge.
    assign tmo_hit = in_hs && !hs_ack && (wd_cnt_reg == WD_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset)                       wd_cnt_reg <= '0;
        else if (state_next != state_reg) wd_cnt_reg <= '0;
        else if (in_hs)                  wd_cnt_reg <= wd_cnt_reg + WD_W'(1);
    end
`else
    assign tmo_hit = 1'b0;
`endif

    dft_seq_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (BUF_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .flush     (start_acc),
        .push      (dft_output_strobe),
        .push_data (dft_output_data),
        .pop       (rd_ready),
        .head_data (rd_data),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

endmodule

// File: tb/tb_dft_run_sequencer.sv
module tb_dft_run_sequencer;

    localparam int DATA_W      = 32;
    localparam int CNT_W       = 16;
    localparam int BUF_DEPTH   = 8;
    localparam int TIMEOUT_CYC = 16;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              cmd_start = 1'b0;
    logic [DATA_W-1:0] cmd_stim = '0;
    logic [CNT_W-1:0]  cmd_ops = '0;
    logic [CNT_W-1:0]  cmd_dumps = '0;
    logic              busy, done;
    logic [1:0]        err;
    logic              dut_rst;
    logic [DATA_W-1:0] dut_input_vec;
    logic              dut_val_op, dut_op_commit;
    logic              dut_op_ack = 1'b0, dut_commit_ack = 1'b0;
    logic              dut_sen;
    logic              dft_val_op, dft_op_commit;
    logic              dft_op_ack = 1'b0, dft_commit_ack = 1'b0;
    logic              dft_output_strobe = 1'b0;
    logic [DATA_W-1:0] dft_output_data = '0;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              rd_ready = 1'b0;

    dft_run_sequencer #(
        .DATA_W      (DATA_W),
        .CNT_W       (CNT_W),
        .BUF_DEPTH   (BUF_DEPTH),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .cmd_start         (cmd_start),
        .cmd_stim          (cmd_stim),
        .cmd_ops           (cmd_ops),
        .cmd_dumps         (cmd_dumps),
        .busy              (busy),
        .done              (done),
        .err               (err),
        .dut_rst           (dut_rst),
        .dut_input_vec     (dut_input_vec),
        .dut_val_op        (dut_val_op),
        .dut_op_commit     (dut_op_commit),
        .dut_op_ack        (dut_op_ack),
        .dut_commit_ack    (dut_commit_ack),
        .dut_sen           (dut_sen),
        .dft_val_op        (dft_val_op),
        .dft_op_commit     (dft_op_commit),
        .dft_op_ack        (dft_op_ack),
        .dft_commit_ack    (dft_commit_ack),
        .dft_output_strobe (dft_output_strobe),
        .dft_output_data   (dft_output_data),
        .rd_data           (rd_data),
        .rd_valid          (rd_valid),
        .rd_ready          (rd_ready)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // ---------------- environment knobs (written by the test only) -------------
    logic              dut_ack_en = 1'b1;
    logic              dft_ack_en = 1'b1;
    int                strobes_per_dump = 0;
    logic              man_strobe = 1'b0;
    logic [DATA_W-1:0] man_data = '0;
    logic              man_ready = 1'b0;

    // ---------------- responder: DUT/DFT partners and host read port ----------
    logic [DATA_W-1:0] next_word = 32'hC0DE_0000;
    int                strobes_left = 0;

    initial begin
        forever begin
            @(posedge clk);
            #1;
            dut_op_ack     = dut_ack_en && dut_val_op;
            dut_commit_ack = dut_ack_en && dut_op_commit;
            rd_ready       = man_ready;
            if (!dut_sen) strobes_left = strobes_per_dump;
            if (man_strobe) begin
                dft_output_strobe = 1'b1;
                dft_output_data   = man_data;
                dft_op_ack        = 1'b0;
            end else if (dft_val_op && strobes_left > 0) begin
                dft_output_strobe = 1'b1;
                dft_output_data   = next_word;
                next_word         = next_word + 1;
                strobes_left      = strobes_left - 1;
                dft_op_ack        = 1'b0;
            end else begin
                dft_output_strobe = 1'b0;
                dft_op_ack        = dft_ack_en && dft_val_op;
            end
            dft_commit_ack = dft_ack_en && dft_op_commit;
        end
    end

    // ---------------- model + per-cycle compare --------------------------------
    int                cyc = 0;
    logic [DATA_W-1:0] mq[$];
    logic              m_ovf = 1'b0;
    logic [DATA_W-1:0] m_stim = '0;
    string             ev_log = "";
    int                last_ack_cyc = 0;
    int                dft_req_cycles = 0;
    int                op_reqs = 0;
    logic [DATA_W-1:0] popped[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (reset) begin
            mq.delete();
            m_ovf  = 1'b0;
            m_stim = '0;
        end
        check("rd_valid", rd_valid, mq.size() != 0);
        if (mq.size() != 0) check("rd_data", rd_data, mq[0]);
        check("err_ovf", err[0], m_ovf);
`ifndef DFT_SEQ_TIMEOUT_EN
        check("err_tmo", err[1], 0);
`endif
        check("stim_vec", dut_input_vec, m_stim);
        check("protocol",
              {($countones({dut_val_op, dut_op_commit, dft_val_op, dft_op_commit, dut_rst}) <= 1),
               (dut_sen == (dft_val_op | dft_op_commit)), !(busy && done)},
              3'b111);
        if (!reset) begin
            if (dut_op_commit && dut_commit_ack) begin ev_log = {ev_log, "O"}; last_ack_cyc = cyc; end
            if (dft_op_commit && dft_commit_ack) begin ev_log = {ev_log, "D"}; last_ack_cyc = cyc; end
            if (dft_val_op) dft_req_cycles++;
            if (dut_val_op && dut_op_ack) op_reqs++;
            if (rd_valid && rd_ready) popped.push_back(rd_data);
            if (cmd_start) begin
                mq.delete();
                m_ovf  = 1'b0;
                m_stim = cmd_stim;
            end else begin
                if (rd_ready && mq.size() > 0) void'(mq.pop_front());
                if (dft_output_strobe) begin
                    if (mq.size() == BUF_DEPTH) m_ovf = 1'b1;
                    else mq.push_back(dft_output_data);
                end
            end
        end
    end

    // ---------------- test tasks ------------------------------------------------
    task automatic do_start(input logic [DATA_W-1:0] stim, input logic [CNT_W-1:0] ops,
                            input logic [CNT_W-1:0] dumps);
        @(posedge clk); #1;
        cmd_stim  = stim;
        cmd_ops   = ops;
        cmd_dumps = dumps;
        cmd_start = 1'b1;
        @(posedge clk); #1;
        cmd_start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget, output int dcyc);
        dcyc = -1;
        for (int i = 0; i < budget; i++) begin
            if (done) begin
                dcyc = cyc;
                break;
            end
            @(posedge clk); #1;
        end
        check(name, dcyc >= 0, 1);
    endtask

    task automatic check_words(input string name, input int p0, input logic [DATA_W-1:0] base,
                               input int n);
        for (int i = 0; i < n; i++) begin
            logic [DATA_W-1:0] w;
            w = (p0 + i < popped.size()) ? popped[p0 + i] : '0;
            check(name, w, base + DATA_W'(i));
        end
    endtask

    function automatic logic [12:0] out_vec();
        return {busy, done, err, dut_rst, |dut_input_vec, dut_val_op, dut_op_commit,
                dut_sen, dft_val_op, dft_op_commit, |rd_data, rd_valid};
    endfunction

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        int d, l0, p0, o0, q0;
        logic [DATA_W-1:0] base;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", out_vec(), 13'h0);
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(posedge clk);

        // 1) ops=3, dumps=0, 1-cycle acks
        l0 = ev_log.len(); o0 = op_reqs; q0 = dft_req_cycles;
        do_start(32'h1234_5678, 16'd3, 16'd0);
        check("t1_T1_busy_rst", {busy, dut_rst, dut_val_op}, 3'b110);
        @(posedge clk); #1;
        check("t1_T2_busy_rst", {busy, dut_rst, dut_val_op}, 3'b110);
        @(posedge clk); #1;
        check("t1_T3_val_op", {busy, dut_rst, dut_val_op}, 3'b101);
        wait_done("t1_done", 100, d);
        check("t1_seq_OOO", ev_log.substr(l0, ev_log.len() - 1) == "OOO", 1);
        check("t1_op_reqs", op_reqs - o0, 3);
        check("t1_no_dft_req", dft_req_cycles - q0, 0);
        check("t1_done_latency", (d - last_ack_cyc >= 1) && (d - last_ack_cyc <= 5), 1);
        check("t1_stim", dut_input_vec, 32'h1234_5678);
        @(posedge clk); #1;
        check("t1_done_pulse", {done, busy}, 2'b00);

        // 2) ops=1, dumps=2, 4 strobes per dump, host draining
        strobes_per_dump = 4;
        man_ready = 1'b1;
        base = next_word;
        l0 = ev_log.len(); p0 = popped.size();
        do_start(32'hA5A5_0001, 16'd1, 16'd2);
        wait_done("t2_done", 300, d);
        repeat (4) @(posedge clk);
        check("t2_seq_ODOD", ev_log.substr(l0, ev_log.len() - 1) == "ODOD", 1);
        check("t2_pops", popped.size() - p0, 8);
        check_words("t2_word", p0, base, 8);
        check("t2_err", err, 2'b00);

        // 3) dumps=1, 10 strobes, host not draining -> overflow
        man_ready = 1'b0;
        strobes_per_dump = 10;
        base = next_word;
        l0 = ev_log.len();
        do_start(32'h0000_0003, 16'd0, 16'd1);
        wait_done("t3_done", 300, d);
        repeat (2) @(posedge clk); #1;
        check("t3_seq_D", ev_log.substr(l0, ev_log.len() - 1) == "D", 1);
        check("t3_err_ovf", err, 2'b01);
        p0 = popped.size();
        man_ready = 1'b1;
        repeat (14) @(posedge clk);
        man_ready = 1'b0;
        check("t3_pops", popped.size() - p0, 8);
        check_words("t3_word", p0, base, 8);

        // 4) full FIFO: strobe coincides with pop -> no overflow, still 8 held
        strobes_per_dump = 0;
        do_start(32'h0000_0004, 16'd0, 16'd0);
        wait_done("t4_done", 50, d);
        @(posedge clk); #1;
        check("t4_err_cleared", err, 2'b00);
        base = 32'h5000_0000;
        p0 = popped.size();
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            man_strobe = 1'b1;
            man_data   = base + DATA_W'(i);
        end
        @(negedge clk);
        man_data  = base + 32'd8;
        man_ready = 1'b1;
        @(negedge clk);
        man_strobe = 1'b0;
        man_ready  = 1'b0;
        repeat (3) @(posedge clk); #1;
        check("t4_no_ovf", err[0], 1'b0);
        check("t4_first_pop", popped.size() - p0, 1);
        man_ready = 1'b1;
        repeat (14) @(posedge clk);
        man_ready = 1'b0;
        check("t4_pops", popped.size() - p0, 9);
        check_words("t4_word", p0, base, 9);

        // 5) reset during DFT_CMT, then a normal run
        d = -1;
        do_start(32'hDEAD_BEEF, 16'd1, 16'd1);
        for (int i = 0; i < 50; i++) begin
            if (dft_op_commit) begin d = i; break; end
            @(posedge clk); #1;
        end
        check("t5_reached_dft_cmt", d >= 0, 1);
        reset = 1'b1;
        #1;
        check("t5_reset_outputs", out_vec(), 13'h0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(posedge clk);
        strobes_per_dump = 2;
        man_ready = 1'b1;
        base = next_word;
        l0 = ev_log.len(); p0 = popped.size();
        do_start(32'h0BAD_F00D, 16'd2, 16'd1);
        wait_done("t5_done", 200, d);
        repeat (3) @(posedge clk); #1;
        check("t5_seq_OOD", ev_log.substr(l0, ev_log.len() - 1) == "OOD", 1);
        check("t5_words", popped.size() - p0, 2);
        check_words("t5_word", p0, base, 2);
        check("t5_err", err, 2'b00);
        man_ready = 1'b0;

`ifdef DFT_SEQ_TIMEOUT_EN
        // 6) DUT never acks -> watchdog
        dut_ack_en = 1'b0;
        do_start(32'h0000_0006, 16'd1, 16'd0);
        wait_done("t6_done", 100, d);
        check("t6_val_op_low", dut_val_op, 1'b0);
        @(posedge clk); #1;
        check("t6_err_tmo", err, 2'b10);
        check("t6_idle", {busy, done}, 2'b00);
        dut_ack_en = 1'b1;
`endif

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
